// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES-128 encryption, one round per clock, round keys expanded on the fly
module aes_cipher_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [127:0] key,
    input  logic [127:0] text_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] text_out
);
    logic [127:0] state, rk, sr, mc, nk;
    logic [31:0]  tw;
    logic [3:0]   rnd;
    logic [7:0]   rcon;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xt(p);
        end
        return r;
    endfunction

    // multiplicative inverse as b^254 (maps 0 to 0), then the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] r, p;
        r = 8'h01;
        p = b;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    always_comb begin
        sr = '0;
        mc = '0;
        nk = '0;
        tw = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[127-8*(4*c+r) -: 8] = sbox(state[127-8*(4*((c+r)%4)+r) -: 8]);
        for (int c = 0; c < 4; c++)
            mc[127-32*c -: 32] = mixcol(sr[127-32*c -: 32]);
        tw = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {rcon, 24'h0};
        nk[127:96] = rk[127:96] ^ tw;
        nk[95:64]  = rk[95:64] ^ nk[127:96];
        nk[63:32]  = rk[63:32] ^ nk[95:64];
        nk[31:0]   = rk[31:0] ^ nk[63:32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            text_out <= '0;
            rnd      <= 4'd0;
            rcon     <= 8'h01;
        end else begin
            done <= 1'b0;
            if (ld) begin
                state <= text_in ^ key;
                rk    <= key;
                rnd   <= 4'd1;
                rcon  <= 8'h01;
                busy  <= 1'b1;
            end else if (busy) begin
                rk   <= nk;
                rcon <= xt(rcon);
                if (rnd == 4'd10) begin
                    text_out <= sr ^ nk;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    rnd      <= 4'd0;
                end else begin
                    state <= mc ^ nk;
                    rnd   <= rnd + 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_cipher_iter.sv
// tb_aes_cipher_iter: scoreboard bench for aes_cipher_iter against a table-driven AES-128 model
module tb_aes_cipher_iter;
    logic         clk = 1'b0;
    logic         rst, ld;
    logic [127:0] key, text_in, text_out;
    logic         busy, done;

    aes_cipher_iter dut (
        .clk(clk), .rst(rst), .ld(ld), .key(key), .text_in(text_in),
        .busy(busy), .done(done), .text_out(text_out)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] RK0 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct packed {
        logic [127:0] ct;
        logic [127:0] rk;
    } exp_t;

    exp_t       q[$];
    logic [7:0] sbt[256];
    int         passed = 0;
    int         total = 0;

    function automatic void chk(input string n, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", n, got, exp);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    // S-box from its definition: brute-force inverse, then bitwise affine map
    function automatic void build_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbt[x] = s;
        end
    endfunction

    function automatic logic [1407:0] expand(input logic [127:0] k);
        logic [1407:0] w;
        logic [31:0]   t;
        logic [7:0]    rc;
        w = '0;
        w[1407 -: 128] = k;
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[1407-32*(i-1) -: 32];
            if (i % 4 == 0) begin
                t = {sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]], sbt[t[31:24]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[1407-32*i -: 32] = w[1407-32*(i-4) -: 32] ^ t;
        end
        return w;
    endfunction

    function automatic logic [127:0] ref_rk(input logic [127:0] k);
        logic [1407:0] w;
        w = expand(k);
        return w[127:0];
    endfunction

    function automatic logic [127:0] ref_ct(input logic [127:0] k, input logic [127:0] p);
        logic [1407:0] w;
        logic [7:0]    s[16], t[16], a[4];
        logic [127:0]  ct;
        w = expand(k);
        for (int n = 0; n < 16; n++) s[n] = p[127-8*n -: 8] ^ w[1407-8*n -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int n = 0; n < 16; n++) t[n] = sbt[s[n]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
            if (r < 10)
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[j] = s[4*c+j];
                    for (int row = 0; row < 4; row++)
                        s[4*c+row] = gm(8'h02, a[row]) ^ gm(8'h03, a[(row+1)%4]) ^ a[(row+2)%4] ^ a[(row+3)%4];
                end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[1407-128*r-8*n -: 8];
        end
        for (int n = 0; n < 16; n++) ct[127-8*n -: 8] = s[n];
        return ct;
    endfunction

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("ciphertext", text_out, e.ct);
                chk("round10_key", dut.rk, e.rk);
            end
        end
    end

    task automatic load(input logic [127:0] k, input logic [127:0] p, input bit push,
                        input logic [127:0] ct, input logic [127:0] rk);
        exp_t e;
        e.ct = ct;
        e.rk = rk;
        if (push) q.push_back(e);
        ld = 1'b1;
        key = k;
        text_in = p;
        @(negedge clk);
        ld = 1'b0;
        key = {$urandom, $urandom, $urandom, $urandom};
        text_in = {$urandom, $urandom, $urandom, $urandom};
        chk("busy_after_ld", {busy, done}, 2'b10);
    endtask

    task automatic wait_done(input bit hold, input logic [127:0] hv);
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            chk("busy_in_rounds", {busy, done}, 2'b10);
            if (hold) chk("text_out_hold", text_out, hv);
        end
        @(negedge clk);
        chk("done_at_10", {busy, done}, 2'b01);
    endtask

    initial begin
        logic [127:0] k, p;
        build_sbox();
        rst = 1'b1;
        ld = 1'b0;
        key = '0;
        text_in = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_text_out", text_out, 0);
        rst = 1'b0;
        @(negedge clk);

        load(KB, PB, 1, CB, ref_rk(KB));
        wait_done(0, 0);
        @(negedge clk);
        chk("idle_after_done", {busy, done}, 2'b00);
        chk("idle_hold", text_out, CB);

        load(K1, P1, 1, C1, ref_rk(K1));
        wait_done(0, 0);
        load(128'h0, 128'h0, 1, C0, RK0);
        wait_done(0, 0);
        @(negedge clk);

        load(KB, PB, 0, 0, 0);
        repeat (3) @(negedge clk);
        load(K1, P1, 1, C1, ref_rk(K1));
        wait_done(0, 0);

        load(KB, PB, 1, CB, ref_rk(KB));
        wait_done(1, C1);

        load(K1, P1, 0, 0, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_text_out", text_out, 0);
        repeat (12) begin
            @(negedge clk);
            chk("no_done_after_rst", {busy, done}, 2'b00);
        end
        load(K1, P1, 1, C1, ref_rk(K1));
        wait_done(0, 0);

        for (int i = 0; i < 8; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(0, 2)) @(negedge clk);
            load(k, p, 1, ref_ct(k, p), ref_rk(k));
            wait_done(0, 0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/aes_cipher_iter.md
# aes_cipher_iter

Iterative AES-128 forward cipher (encryption): one round per clock, round keys expanded on the fly from the 128-bit key loaded with each block. It is the encrypt-side counterpart to the inverse cipher in the AES core. Its ciphertext feeds that block directly for loopback checks. There is no separate key-load phase: key and plaintext are presented together on `ld`.

## Interface
- Parameters: none (AES-128 only, 10 rounds fixed).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `ld`  in  1  start strobe; samples `key` and `text_in` on the edge where high.
- `key`  in  128  cipher key; byte 0 = `[127:120]`.
- `text_in`  in  128  plaintext; byte 0 = `[127:120]`; state is column-major as in FIPS-197 (bytes 0-3 = column 0).
- `busy`  out  1  high while rounds are in progress.
- `done`  out  1  one-cycle pulse; `text_out` is valid and new.
- `text_out`  out  128  ciphertext, registered; holds until the next completion.

## Operation
- Registers:
  - `state` [127:0];
  - `rk` [127:0] (current round key);
  - `rnd` [3:0];
  - `rcon` [7:0];
  - `busy`, `done`, `text_out`.
- Reset (`rst`=1 at edge): `busy`=0, `done`=0, `text_out`=0, `rnd`=0, `rcon`=8'h01. `state` and `rk` are don't-care.
- Load (`ld`=1, `rst`=0):
  - `state` <= `text_in` ^ `key` (initial AddRoundKey);
  - `rk` <= `key`;
  - `rnd` <= 1, `rcon` <= 8'h01, `busy` <= 1.
- Round step (`busy`=1, `ld`=0):
  - Next key: `w0'` = `w0` ^ SubWord(RotWord(`w3`)) ^ {`rcon`,24'h0}; `w1'` = `w1`^`w0'`; `w2'` = `w2`^`w1'`; `w3'` = `w3`^`w2'`.
  - `rk` <= next key.
  - `rnd` 1..9: `state` <= MixColumns(ShiftRows(SubBytes(`state`))) ^ next key.
  - `rnd`=10: skip MixColumns; write the result to `text_out`. Set `done` <= 1, `busy` <= 0, `rnd` <= 0.
  - `rcon` <= xtime(`rcon`) in GF(2^8), reduction polynomial 0x11b. The sequence is 01,02,04,08,10,20,40,80,1b,36.
- S-box: 20 combinational forward S-box lookups (16 state, 4 key schedule). Instantiate `aes_sbox` or an equivalent ROM; there is no registered lookup inside the round.
- MixColumns coefficients per column are {02,03,01,01} rotated; xtime = {b[6:0],0} ^ (8'h1b & {8{b[7]}}).
- ShiftRows: row r rotates left by r columns.
- Priority: `rst` > `ld` > round step.
  - `ld` while `busy` aborts the current block with no `done` and restarts with the new inputs.
  - `ld` in the same cycle as `done`=1 is accepted normally.
- `done` is 0 on every cycle except the single completion cycle. `ld` never asserts `done`.
- Idle (`busy`=0, no `ld`): all registers hold; `done`=0.

## Timing
- Edge E0 samples `ld`=1. Edges E1..E10 execute rounds 1..10.
- After E10: `text_out` = ciphertext, `done`=1, `busy`=0. Latency is 10 cycles from the `ld` edge.
- `busy`=1 after E0 through E9 (10 cycles).
- Throughput: one block per 11 cycles if `ld` is pulsed on the `done` cycle; one per 10 cycles is not supported.
- `rst` mid-block: next cycle `busy`=0, `done`=0, `text_out`=0. No completion is signalled.
- `text_out` changes only on the completion edge or on reset.
- Inputs need only be valid on the `ld` edge.

## Test plan
- FIPS-197 App. B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, `ld` one cycle.
  - Required: `done` exactly 10 cycles later with `text_out`=3925841d02dc09fbdc118597196a0b32; `busy` high for 10 cycles.
- FIPS-197 C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Required: `text_out`=69c4e0d86a7b0430d8cdb78070b4c55a.
- All-zero vector:
  - Stimulus: key 0, pt 0.
  - Required: `text_out`=66e94bd4ef8a2c3b884cfa59ca342b2e. Also check the round-10 key equals b4ef5bcb3e92e21123e951cf6f8f188e.
- Abort/restart:
  - Stimulus: App. B load, then C.1 `ld` 4 cycles later.
  - Required: exactly one `done`, 10 cycles after the second `ld`, with the C.1 ciphertext.
- Back-to-back:
  - Stimulus: C.1 load, then App. B `ld` asserted in the `done` cycle.
  - Required: two `done` pulses 11 cycles apart carrying the correct ciphertexts in order; `text_out` holds the first result until the second completion.
- Reset mid-block:
  - Stimulus: `rst`=1 at round 5.
  - Required: next cycle `busy`=0, `done`=0, `text_out`=0; no `done` follows until a new `ld`, after which the C.1 result is correct.
